tsf_event_sched: RTL and testbench

- Consumes the free-running TSF count produced by the TSF timer and raises one-shot or periodic events when TSF reaches a programmed target.
- Typical uses: TBTT/beacon scheduling and timed TX triggers. It also gives an early warning a programmable number of ticks ahead of each target.
- Sits directly downstream of the TSF timer inside xpu. Outputs go to the TX control logic and the interrupt logic.

---
 rtl/tsf_event_sched.sv | 165 ++++++++++++++++
 tb/tb_tsf_event_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsf_event_sched.sv
// tsf_event_sched: watches the free-running TSF and raises one-shot or
// periodic events at a programmed target, with an optional early warning
// a fixed number of ticks ahead of each target.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | not scheduled; waiting for arm
//   SETTLE | target just (re)loaded; registered compares are stale
//   ARMED  | compares valid; waiting for hit, handling early warning
//   FIRE   | event_pulse cycle; reload next period or return to IDLE
module tsf_event_sched #(
  parameter int TIMER_WIDTH  = 64,
  parameter int PERIOD_WIDTH = 32,
  parameter int LEAD_WIDTH   = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [TIMER_WIDTH-1:0]  tsf_runtime_val,
  input  logic                    arm,
  input  logic                    disarm,
  input  logic [TIMER_WIDTH-1:0]  target_tsf,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [LEAD_WIDTH-1:0]   lead_time,
  input  logic                    cnt_clr,
  output logic                    armed,
  output logic                    early_pulse,
  output logic                    event_pulse,
  output logic                    event_late,
  output logic [TIMER_WIDTH-1:0]  event_tsf,
  output logic [CNT_WIDTH-1:0]    event_cnt,
  output logic [CNT_WIDTH-1:0]    miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ARMED  = 2'd2,
    S_FIRE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TIMER_WIDTH-1:0]  tgt;
  logic [PERIOD_WIDTH-1:0] per;
  logic [LEAD_WIDTH-1:0]   lead;
  logic                    adv;
  logic                    early_done;
  logic                    first_cmp;
  logic                    hit_r;
  logic                    early_r;
  logic [TIMER_WIDTH-1:0]  tsf_d;

  logic [TIMER_WIDTH:0]    early_sum;
  logic [TIMER_WIDTH-1:0]  tgt_step;
  logic                    restart;
  logic                    watch;
  logic                    do_fire;
  logic                    do_miss;
  logic                    do_step;

  // one extra bit so tsf + lead never wraps in the early compare
  assign early_sum = {1'b0, tsf_runtime_val} + (TIMER_WIDTH+1)'(lead);
  assign tgt_step  = tgt + TIMER_WIDTH'(per);
  // arm restarts from any state unless disarm is also present
  assign restart   = arm & ~disarm;

  // compare stage: register hit/early against the current target
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_r   <= 1'b0;
      early_r <= 1'b0;
      tsf_d   <= '0;
    end else begin
      hit_r   <= (tsf_runtime_val >= tgt);
      early_r <= (early_sum >= {1'b0, tgt});
      tsf_d   <= tsf_runtime_val;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; disarm beats arm, both beat normal sequencing
  always_comb begin
    state_nxt = state;
    if (disarm) begin
      state_nxt = S_IDLE;
    end else if (arm) begin
      state_nxt = S_SETTLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_SETTLE: state_nxt = S_ARMED;
        S_ARMED:  if (hit_r) state_nxt = adv ? S_SETTLE : S_FIRE;
        S_FIRE:   state_nxt = (per == '0) ? S_IDLE : S_SETTLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // output and action decode for the current state
  always_comb begin
    armed       = (state != S_IDLE);
    event_pulse = (state == S_FIRE);
    watch       = (state == S_ARMED) & ~arm & ~disarm;
    early_pulse = watch & ~hit_r & early_r & (lead != '0) & ~early_done;
    do_fire     = watch & hit_r & ~adv;
    do_miss     = watch & hit_r & adv;
    do_step     = (state == S_FIRE) & ~arm & ~disarm & (per != '0);
  end

  // schedule registers: target, period, lead, flags and event capture
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt        <= '0;
      per        <= '0;
      lead       <= '0;
      adv        <= 1'b0;
      early_done <= 1'b0;
      first_cmp  <= 1'b0;
      event_tsf  <= '0;
      event_late <= 1'b0;
    end else if (restart) begin
      tgt        <= target_tsf;
      per        <= period;
      lead       <= lead_time;
      adv        <= 1'b0;
      early_done <= 1'b0;
      first_cmp  <= 1'b1;
    end else begin
      if (watch) begin
        first_cmp <= 1'b0;
        if (!hit_r) adv <= 1'b0;
      end
      if (early_pulse) early_done <= 1'b1;
      if (do_fire) begin
        event_tsf  <= tsf_d;
        event_late <= first_cmp;
      end
      // adv stays set across a miss so every stale period is skipped
      if (do_miss) tgt <= tgt_step;
      if (do_step) begin
        tgt        <= tgt_step;
        adv        <= 1'b1;
        early_done <= 1'b0;
      end
    end
  end

  // saturating event and miss counters; clear beats increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      event_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      if (event_pulse && (event_cnt != '1)) event_cnt <= event_cnt + CNT_WIDTH'(1);
      if (do_miss && (miss_cnt != '1))      miss_cnt  <= miss_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tsf_event_sched.sv
// Bench for tsf_event_sched: directed scenarios plus randomized arm/disarm/
// clear/reset/TSF-jump traffic, compared every cycle against a behavioural
// model that reasons in terms of "scheduled / reloading / firing".
module tb_tsf_event_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        disarm = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [63:0] tsf_in = 64'd0;
  logic [63:0] target_tsf = 64'd0;
  logic [31:0] period = 32'd0;
  logic [15:0] lead_time = 16'd0;

  logic        armed, early_pulse, event_pulse, event_late;
  logic [63:0] event_tsf;
  logic [15:0] event_cnt, miss_cnt;

  logic        s_armed, s_early, s_event, s_late;
  logic [63:0] s_evtsf;
  logic [3:0]  s_evcnt, s_miss;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  tsf_event_sched u_dut (
    .clk(clk), .rst(rst), .tsf_runtime_val(tsf_in), .arm(arm), .disarm(disarm),
    .target_tsf(target_tsf), .period(period), .lead_time(lead_time), .cnt_clr(cnt_clr),
    .armed(armed), .early_pulse(early_pulse), .event_pulse(event_pulse),
    .event_late(event_late), .event_tsf(event_tsf), .event_cnt(event_cnt), .miss_cnt(miss_cnt)
  );

  // narrow counters so saturation is reachable in a short run
  tsf_event_sched #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .tsf_runtime_val(tsf_in), .arm(arm), .disarm(disarm),
    .target_tsf(target_tsf), .period(period), .lead_time(lead_time), .cnt_clr(cnt_clr),
    .armed(s_armed), .early_pulse(s_early), .event_pulse(s_event),
    .event_late(s_late), .event_tsf(s_evtsf), .event_cnt(s_evcnt), .miss_cnt(s_miss)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          chk_en = 1'b0;
  bit          m_run, m_blind, m_fire, m_adv, m_edone, m_first, m_late;
  logic [63:0] m_tgt, m_evtsf, prev_tsf;
  logic [31:0] m_per;
  logic [15:0] m_lead;
  int unsigned ev_n, miss_n;

  function automatic bit m_early_cond();
    logic [64:0] s;
    s = {1'b0, prev_tsf} + {49'd0, m_lead};
    return (prev_tsf < m_tgt) && (m_lead != 16'd0) && !m_edone && (s >= {1'b0, m_tgt});
  endfunction

  function automatic logic [63:0] satv(input int unsigned n, input int unsigned mx);
    return (n > mx) ? 64'(mx) : 64'(n);
  endfunction

  always @(posedge clk) begin
    bit fired_now;
    fired_now = m_fire;
    if (rst) begin
      m_run = 0; m_blind = 0; m_fire = 0; m_adv = 0; m_edone = 0; m_first = 0; m_late = 0;
      m_tgt = '0; m_evtsf = '0; m_per = '0; m_lead = '0; ev_n = 0; miss_n = 0;
      chk_en = 1'b1;
    end else begin
      if (disarm) begin
        m_run = 0; m_blind = 0; m_fire = 0;
      end else if (arm) begin
        m_tgt = target_tsf; m_per = period; m_lead = lead_time;
        m_adv = 0; m_edone = 0; m_first = 1;
        m_run = 1; m_blind = 1; m_fire = 0;
      end else if (m_run) begin
        if (m_fire) begin
          m_fire = 0;
          if (m_per == 32'd0) m_run = 0;
          else begin m_tgt = m_tgt + {32'd0, m_per}; m_adv = 1; m_edone = 0; m_blind = 1; end
        end else if (m_blind) begin
          m_blind = 0;
        end else begin
          if (prev_tsf >= m_tgt) begin
            if (!m_adv) begin m_fire = 1; m_evtsf = prev_tsf; m_late = m_first; end
            else begin miss_n++; m_tgt = m_tgt + {32'd0, m_per}; m_blind = 1; end
          end else begin
            if (m_early_cond()) m_edone = 1;
            m_adv = 0;
          end
          m_first = 0;
        end
      end
      if (cnt_clr) begin ev_n = 0; miss_n = 0; end
      else if (fired_now) ev_n++;
    end
    prev_tsf = tsf_in;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_early;
      exp_early = m_run && !m_blind && !m_fire && !arm && !disarm && m_early_cond();
      chk("armed", armed, m_run);
      chk("early_pulse", early_pulse, exp_early);
      chk("event_pulse", event_pulse, m_fire);
      chk("event_late", event_late, m_late);
      chk("event_tsf", event_tsf, m_evtsf);
      chk("event_cnt", event_cnt, satv(ev_n, 32'hFFFF));
      chk("miss_cnt", miss_cnt, satv(miss_n, 32'hFFFF));
      chk("sat_armed", s_armed, m_run);
      chk("sat_early", s_early, exp_early);
      chk("sat_event", s_event, m_fire);
      chk("sat_late", s_late, m_late);
      chk("sat_event_tsf", s_evtsf, m_evtsf);
      chk("sat_event_cnt", s_evcnt, satv(ev_n, 15));
      chk("sat_miss_cnt", s_miss, satv(miss_n, 15));
    end
  end

  // pulse recorder for the directed literal checks
  logic [63:0] ev_tsf_q[$], ev_at_q[$], ev_late_q[$], early_at_q[$];
  always @(negedge clk) begin
    if (event_pulse) begin
      ev_tsf_q.push_back(event_tsf);
      ev_at_q.push_back(tsf_in);
      ev_late_q.push_back({63'd0, event_late});
    end
    if (early_pulse) early_at_q.push_back(tsf_in);
  end

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  task automatic clear_q();
    ev_tsf_q.delete(); ev_at_q.delete(); ev_late_q.delete(); early_at_q.delete();
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    arm = 1'b0; disarm = 1'b0; cnt_clr = 1'b0;
    tsf_in = tsf_in + 64'd1;
  endtask

  task automatic do_arm(input logic [63:0] t, input logic [31:0] p, input logic [15:0] l);
    target_tsf = t; period = p; lead_time = l; arm = 1'b1;
    tick();
  endtask

  task automatic stop_and_clear();
    disarm = 1'b1; cnt_clr = 1'b1;
    tick();
    clear_q();
  endtask

  initial begin
    int n;
    int r;
    // reset
    tsf_in = 64'd900;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_armed", armed, 0);
    chk("rst_event_pulse", event_pulse, 0);
    chk("rst_event_tsf", event_tsf, 0);
    chk("rst_event_cnt", event_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    // one-shot at 1000
    tsf_in = 64'd900; clear_q();
    do_arm(64'd1000, 32'd0, 16'd0);
    while (tsf_in < 64'd1012) tick();
    chk("s1_n_events", ev_tsf_q.size(), 1);
    chk("s1_event_tsf", qat(ev_tsf_q, 0), 64'd1000);
    chk("s1_latency", qat(ev_at_q, 0), 64'd1002);
    chk("s1_late", qat(ev_late_q, 0), 0);
    chk("s1_armed_drop", armed, 0);
    chk("s1_event_cnt", event_cnt, 1);

    // periodic with early warning
    stop_and_clear();
    tsf_in = 64'd0;
    do_arm(64'd500, 32'd200, 16'd50);
    while (tsf_in < 64'd950) tick();
    chk("s2_n_events", ev_tsf_q.size(), 3);
    chk("s2_ev0", qat(ev_tsf_q, 0), 64'd500);
    chk("s2_ev1", qat(ev_tsf_q, 1), 64'd700);
    chk("s2_ev2", qat(ev_tsf_q, 2), 64'd900);
    chk("s2_at2", qat(ev_at_q, 2), 64'd902);
    chk("s2_n_early", early_at_q.size(), 3);
    chk("s2_early0", qat(early_at_q, 0), 64'd451);
    chk("s2_early1", qat(early_at_q, 1), 64'd651);
    chk("s2_early2", qat(early_at_q, 2), 64'd851);
    chk("s2_miss", miss_cnt, 0);

    // late arm, skipped periods
    stop_and_clear();
    tsf_in = 64'd5000;
    do_arm(64'd100, 32'd1000, 16'd0);
    while (tsf_in < 64'd5110) tick();
    chk("s3_n_events", ev_tsf_q.size(), 2);
    chk("s3_ev0", qat(ev_tsf_q, 0), 64'd5001);
    chk("s3_late0", qat(ev_late_q, 0), 1);
    chk("s3_ev1", qat(ev_tsf_q, 1), 64'd5100);
    chk("s3_late1", qat(ev_late_q, 1), 0);
    chk("s3_miss", miss_cnt, 4);
    chk("s3_event_cnt", event_cnt, 2);

    // backward TSF reload, then forward jump past target
    stop_and_clear();
    tsf_in = 64'd20000;
    do_arm(64'd20050, 32'd100, 16'd0);
    while (tsf_in < 64'd20060) tick();
    tsf_in = tsf_in - 64'd10000;
    repeat (200) tick();
    chk("s4_no_event_after_back", ev_tsf_q.size(), 1);
    tsf_in = 64'd20200;
    repeat (10) tick();
    chk("s4_n_events", ev_tsf_q.size(), 2);
    chk("s4_fwd_tsf", qat(ev_tsf_q, 1), 64'd20200);
    chk("s4_fwd_late", qat(ev_late_q, 1), 0);
    chk("s4_miss", miss_cnt, 0);

    // arm and disarm together
    stop_and_clear();
    target_tsf = 64'd10; period = 32'd5; arm = 1'b1; disarm = 1'b1;
    tick();
    chk("s5_arm_disarm", armed, 0);
    tick();
    chk("s5_arm_disarm_2", armed, 0);

    // disarm one cycle before the hit
    tsf_in = 64'd3000; clear_q();
    do_arm(64'd3020, 32'd0, 16'd0);
    while (tsf_in < 64'd3020) tick();
    tick();
    disarm = 1'b1;
    repeat (6) tick();
    chk("s5_suppressed", ev_tsf_q.size(), 0);
    chk("s5_cnt", event_cnt, 0);

    // reset during FIRE
    tsf_in = 64'd4000;
    do_arm(64'd4020, 32'd0, 16'd0);
    while (tsf_in < 64'd4020) tick();
    tick();
    tick();
    chk("s5_in_fire", event_pulse, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_pulse", event_pulse, 0);
    chk("s5_rst_armed", armed, 0);
    chk("s5_rst_cnt", event_cnt, 0);
    chk("s5_rst_tsf", event_tsf, 0);
    chk("s5_rst_late", event_late, 0);

    // event counter saturation, then clear coincident with an event
    stop_and_clear();
    tsf_in = 64'd30000;
    do_arm(64'd30010, 32'd5, 16'd2);
    repeat (120) tick();
    chk("s6_sat_event_cnt", s_evcnt, 15);
    chk("s6_main_above_sat", (event_cnt > 16'd15), 1);
    n = 0;
    while (!event_pulse && n < 20) begin tick(); n++; end
    chk("s6_found_event", event_pulse, 1);
    cnt_clr = 1'b1;
    tick();
    chk("s6_clr_wins", event_cnt, 0);
    chk("s6_clr_wins_sat", s_evcnt, 0);

    // miss counter saturation
    stop_and_clear();
    tsf_in = 64'd100000;
    do_arm(64'd0, 32'd1, 16'd0);
    repeat (50) tick();
    chk("s7_sat_miss", s_miss, 15);
    chk("s7_main_miss_above", (miss_cnt > 16'd15), 1);
    stop_and_clear();

    // randomized traffic
    tsf_in = 64'd1000000;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) tsf_in = 64'hFFFF_FFFF_FFFF_FE00;
      r = int'($urandom_range(0, 999));
      if (r < 25) begin
        arm = 1'b1;
        target_tsf = tsf_in + 64'($urandom_range(0, 120)) - 64'd30;
        period = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
        lead_time = 16'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) == 0) disarm = 1'b1;
      if ($urandom_range(0, 99) == 0) cnt_clr = 1'b1;
      if ($urandom_range(0, 99) == 0) tsf_in = tsf_in + 64'($urandom_range(0, 200)) - 64'd100;
      rst = ($urandom_range(0, 999) < 3);
      tick();
      rst = 1'b0;
    end
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
